// File: rtl/sprite_fetch.sv
// Per-scanline sprite pattern fetch: walks the 8 secondary-OAM slots in cycles
// 256-319 and hands each slot to a sprite shifter. Flip support: SPRITE_FETCH_FLIP_EN.
module sprite_fetch (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_ce,
    input  logic [8:0]  i_cycle,
    input  logic [8:0]  i_scanline,
    input  logic        i_render_en,
    input  logic        i_obj_size,
    input  logic        i_obj_base,
    input  logic [7:0]  i_oam_bus,
    output logic [13:0] o_vram_addr,
    output logic        o_vram_rd,
    input  logic [7:0]  i_vram_data,
    output logic [3:0]  o_load,
    output logic [26:0] o_load_in,
    output logic [2:0]  o_slot,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LATCH    = 2'd1,
        ST_FETCH_LO = 2'd2,
        ST_FETCH_HI = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [3:0]  r_row;
    logic        r_empty;
    logic [7:0]  r_tile;
    logic [1:0]  r_pal;
    logic        r_prio;
    logic [7:0]  r_x;
    logic [7:0]  r_lo;
    logic [8:0]  r_next_cycle;
    logic [3:0]  r_load;
    logic [26:0] r_load_in;

    logic        w_active;
    logic        w_start;
    logic        w_contig;
    logic        w_run;
    logic [2:0]  w_off;
    logic        w_vflip;
    logic        w_hflip;
    logic [3:0]  w_row;
    logic        w_plane;
    logic [13:0] w_addr;
    logic [7:0]  w_pix_lo;
    logic [7:0]  w_pix_hi;

    function automatic logic [7:0] bit_rev(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

`ifdef SPRITE_FETCH_FLIP_EN
    logic r_vflip;
    logic r_hflip;
    assign w_vflip = r_vflip;
    assign w_hflip = r_hflip;
`else
    assign w_vflip = 1'b0;
    assign w_hflip = 1'b0;
`endif

    assign w_active = i_render_en && ((i_scanline <= 9'd239) || (i_scanline == 9'd261));
    assign w_start  = w_active && (i_cycle == 9'd256) && !i_rst;
    assign w_contig = (i_cycle == r_next_cycle);
    // A slot is only worked on while rendering stays on and the cycle count is unbroken.
    assign w_run    = w_active && w_contig && (r_state != ST_IDLE);
    assign w_off    = i_cycle[2:0];

    assign w_row    = w_vflip ? ~r_row : r_row;
    assign w_plane  = (r_state == ST_FETCH_HI);
    assign w_addr   = i_obj_size ? {1'b0, r_tile[0], r_tile[7:1], w_row[3], w_plane, w_row[2:0]}
                                 : {1'b0, i_obj_base, r_tile, w_plane, w_row[2:0]};

    assign w_pix_lo = r_empty ? 8'h00 : (w_hflip ? r_lo : bit_rev(r_lo));
    assign w_pix_hi = r_empty ? 8'h00 : (w_hflip ? i_vram_data : bit_rev(i_vram_data));

    assign o_vram_addr = (w_run && (r_state == ST_FETCH_LO || r_state == ST_FETCH_HI)) ? w_addr : 14'd0;
    assign o_vram_rd   = w_run && (((r_state == ST_FETCH_LO) && (w_off == 3'd4)) ||
                                   ((r_state == ST_FETCH_HI) && (w_off == 3'd6)));
    assign o_busy      = w_run || w_start;
    assign o_slot      = i_cycle[5:3];
    assign o_load      = r_load;
    assign o_load_in   = r_load_in;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else if (i_ce) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_start) begin
            w_state_nxt = ST_LATCH;
        end else if (r_state != ST_IDLE && !(w_active && w_contig)) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_LATCH:    if (w_off == 3'd3) w_state_nxt = ST_FETCH_LO;
                ST_FETCH_LO: if (w_off == 3'd5) w_state_nxt = ST_FETCH_HI;
                ST_FETCH_HI: if (w_off == 3'd7)
                                 w_state_nxt = (i_cycle[5:3] == 3'd7) ? ST_IDLE : ST_LATCH;
                default:     w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_row        <= 4'd0;
            r_empty      <= 1'b0;
            r_tile       <= 8'd0;
            r_pal        <= 2'd0;
            r_prio       <= 1'b0;
            r_x          <= 8'd0;
            r_lo         <= 8'd0;
            r_next_cycle <= 9'd0;
            r_load       <= 4'd0;
            r_load_in    <= 27'd0;
`ifdef SPRITE_FETCH_FLIP_EN
            r_vflip      <= 1'b0;
            r_hflip      <= 1'b0;
`endif
        end else if (i_ce) begin
            r_next_cycle <= i_cycle + 9'd1;
            r_load       <= 4'd0;
            if (w_start) begin
                r_row   <= i_oam_bus[3:0];
                r_empty <= |i_oam_bus[7:4];
            end else if (w_run) begin
                case (r_state)
                    ST_LATCH: begin
                        case (w_off)
                            3'd0: begin
                                r_row   <= i_oam_bus[3:0];
                                r_empty <= |i_oam_bus[7:4];
                            end
                            3'd1: r_tile <= i_oam_bus;
                            3'd2: begin
                                r_pal  <= i_oam_bus[1:0];
                                r_prio <= i_oam_bus[5];
`ifdef SPRITE_FETCH_FLIP_EN
                                r_vflip <= i_oam_bus[7];
                                r_hflip <= i_oam_bus[6];
`endif
                            end
                            3'd3: r_x <= i_oam_bus;
                            default: ;
                        endcase
                    end
                    ST_FETCH_LO: if (w_off == 3'd5) r_lo <= i_vram_data;
                    ST_FETCH_HI: if (w_off == 3'd7) begin
                        r_load    <= 4'b1111;
                        r_load_in <= {w_pix_lo, w_pix_hi, r_x, r_pal, r_prio};
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sprite_fetch.sv
// Directed bench for sprite_fetch: scanline sweeps over hand-built secondary-OAM
// tables, with address/load scoreboards and reset, abort and jump cases.
module tb_sprite_fetch;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_ce;
    logic [8:0]  i_cycle;
    logic [8:0]  i_scanline;
    logic        i_render_en;
    logic        i_obj_size;
    logic        i_obj_base;
    logic [7:0]  i_oam_bus;
    logic [13:0] o_vram_addr;
    logic        o_vram_rd;
    logic [7:0]  i_vram_data;
    logic [3:0]  o_load;
    logic [26:0] o_load_in;
    logic [2:0]  o_slot;
    logic        o_busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  t_row [8];
    logic [7:0]  t_tile[8];
    logic [7:0]  t_attr[8];
    logic [7:0]  t_x   [8];
    logic [7:0]  t_lo  [8];
    logic [7:0]  t_hi  [8];
    logic [13:0] e_lo  [8];
    logic [13:0] e_hi  [8];
    logic [26:0] e_load[8];

    logic [13:0] exp_addr_q[$];
    logic [26:0] exp_load_q[$];

    sprite_fetch dut (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_ce        (i_ce),
        .i_cycle     (i_cycle),
        .i_scanline  (i_scanline),
        .i_render_en (i_render_en),
        .i_obj_size  (i_obj_size),
        .i_obj_base  (i_obj_base),
        .i_oam_bus   (i_oam_bus),
        .o_vram_addr (o_vram_addr),
        .o_vram_rd   (o_vram_rd),
        .i_vram_data (i_vram_data),
        .o_load      (o_load),
        .o_load_in   (o_load_in),
        .o_slot      (o_slot),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_cleared(input string name);
        check({name, "_rd"},      o_vram_rd,   0);
        check({name, "_addr"},    o_vram_addr, 0);
        check({name, "_busy"},    o_busy,      0);
        check({name, "_load"},    o_load,      0);
        check({name, "_load_in"}, o_load_in,   0);
    endtask

    // Slot 0 from the 8x8 reference vector, two populated slots, slots 3-7 empty.
    task automatic setup_a();
        t_row[0] = 8'h03; t_tile[0] = 8'h42; t_attr[0] = 8'h01; t_x[0] = 8'h84;
        t_lo[0]  = 8'h80; t_hi[0]   = 8'h01;
        e_lo[0] = 14'h1423; e_hi[0] = 14'h142B; e_load[0] = {8'h01, 8'h80, 8'h84, 2'b01, 1'b0};
        t_row[1] = 8'h07; t_tile[1] = 8'h10; t_attr[1] = 8'h22; t_x[1] = 8'h05;
        t_lo[1]  = 8'h0F; t_hi[1]   = 8'hF0;
        e_lo[1] = 14'h1107; e_hi[1] = 14'h110F; e_load[1] = {8'hF0, 8'h0F, 8'h05, 2'b10, 1'b1};
        t_row[2] = 8'h00; t_tile[2] = 8'hFF; t_attr[2] = 8'h03; t_x[2] = 8'hFF;
        t_lo[2]  = 8'hAA; t_hi[2]   = 8'h55;
        e_lo[2] = 14'h1FF0; e_hi[2] = 14'h1FF8; e_load[2] = {8'h55, 8'hAA, 8'hFF, 2'b11, 1'b0};
        for (int k = 3; k < 8; k++) begin
            t_row[k] = 8'hFF; t_tile[k] = 8'h00; t_attr[k] = 8'h00; t_x[k] = 8'h30 + 8'(k);
            t_lo[k]  = 8'hFF; t_hi[k]   = 8'hFF;
            e_lo[k] = 14'h1007; e_hi[k] = 14'h100F;
            e_load[k] = {8'h00, 8'h00, 8'h30 + 8'(k), 2'b00, 1'b0};
        end
    endtask

    // 8x16 table: vertical flip on slot 0, horizontal flip on slot 1.
    task automatic setup_c();
        t_row[0] = 8'h0A; t_tile[0] = 8'h43; t_attr[0] = 8'h80; t_x[0] = 8'h10;
        t_lo[0]  = 8'h12; t_hi[0]   = 8'h34;
        e_load[0] = {8'h48, 8'h2C, 8'h10, 2'b00, 1'b0};
        t_row[1] = 8'h01; t_tile[1] = 8'h20; t_attr[1] = 8'h40; t_x[1] = 8'h20;
        t_lo[1]  = 8'h80; t_hi[1]   = 8'h03;
        e_lo[1] = 14'h0201; e_hi[1] = 14'h0209;
`ifdef SPRITE_FETCH_FLIP_EN
        e_lo[0] = 14'h1425; e_hi[0] = 14'h142D;
        e_load[1] = {8'h80, 8'h03, 8'h20, 2'b00, 1'b0};
`else
        e_lo[0] = 14'h1432; e_hi[0] = 14'h143A;
        e_load[1] = {8'h01, 8'hC0, 8'h20, 2'b00, 1'b0};
`endif
        for (int k = 2; k < 8; k++) begin
            t_row[k] = 8'hFF; t_tile[k] = 8'h00; t_attr[k] = 8'h00; t_x[k] = 8'h40 + 8'(k);
            t_lo[k]  = 8'hFF; t_hi[k]   = 8'hFF;
            e_lo[k] = 14'h0017; e_hi[k] = 14'h001F;
            e_load[k] = {8'h00, 8'h00, 8'h40 + 8'(k), 2'b00, 1'b0};
        end
    endtask

    // One scanline sweep over cycles 250-329 with optional abort, reset and cycle jump.
    task automatic run_line(input string name, input bit ce_tog, input int drop_cyc,
                            input int rst_cyc, input int jump_from, input int jump_to,
                            input int n_loads, input int n_rd, input bit chk_busy);
        int cyc;
        int slot;
        int off;
        int n_rd_seen;
        int n_load_evt;
        int n_load_clk;
        bit prev_load;
        n_rd_seen = 0; n_load_evt = 0; n_load_clk = 0; prev_load = 1'b0;
        exp_addr_q.delete();
        exp_load_q.delete();
        for (int i = 0; i < n_rd; i++)
            exp_addr_q.push_back((i % 2 == 0) ? e_lo[i/2] : e_hi[i/2]);
        for (int i = 0; i < n_loads; i++)
            exp_load_q.push_back(e_load[i]);
        i_render_en = 1'b1;
        cyc = 250;
        while (cyc < 330) begin
            if (cyc == jump_from) cyc = jump_to;
            if (cyc == drop_cyc) i_render_en = 1'b0;
            slot = (cyc >> 3) & 7;
            off  = cyc & 7;
            i_cycle = 9'(cyc);
            i_oam_bus = 8'h5A;
            i_vram_data = 8'hC3;
            if (cyc >= 256 && cyc <= 319) begin
                case (off)
                    0: i_oam_bus = t_row[slot];
                    1: i_oam_bus = t_tile[slot];
                    2: i_oam_bus = t_attr[slot];
                    3: i_oam_bus = t_x[slot];
                    5: i_vram_data = t_lo[slot];
                    7: i_vram_data = t_hi[slot];
                    default: ;
                endcase
            end
            for (int k = 0; k < (ce_tog ? 2 : 1); k++) begin
                i_ce = (k == (ce_tog ? 1 : 0));
                if (k == 0 && rst_cyc != 0 && cyc == rst_cyc + 2) i_rst = 1'b0;
                #1;
                if (k == 0 && o_vram_rd) begin
                    if (exp_addr_q.size() > 0)
                        check($sformatf("%s_addr%0d", name, n_rd_seen), o_vram_addr, exp_addr_q.pop_front());
                    n_rd_seen++;
                end
                if (k == 0 && chk_busy) begin
                    if (cyc == 255) check({name, "_busy255"}, o_busy, 0);
                    if (cyc == 256) check({name, "_busy256"}, o_busy, 1);
                    if (cyc == 256) check({name, "_slot256"}, o_slot, 0);
                    if (cyc == 300) check({name, "_slot300"}, o_slot, 5);
                    if (cyc == 319) check({name, "_busy319"}, o_busy, 1);
                    if (cyc == 320) check({name, "_busy320"}, o_busy, 0);
                end
                if (k == 0 && cyc == rst_cyc) begin
                    i_rst = 1'b1;
                    #1;
                    check_cleared({name, "_rst"});
                end
                @(posedge clk);
                #1;
                if (o_load != 4'd0) begin
                    n_load_clk++;
                    if (!prev_load) begin
                        check($sformatf("%s_mask%0d", name, n_load_evt), o_load, 4'hF);
                        if (exp_load_q.size() > 0)
                            check($sformatf("%s_load%0d", name, n_load_evt), o_load_in, exp_load_q.pop_front());
                        n_load_evt++;
                    end
                end
                prev_load = (o_load != 4'd0);
            end
            cyc++;
        end
        check({name, "_rd_count"},    n_rd_seen,  n_rd);
        check({name, "_load_count"},  n_load_evt, n_loads);
        check({name, "_load_clocks"}, n_load_clk, n_loads * (ce_tog ? 2 : 1));
    endtask

    initial begin
        i_rst = 1'b1; i_ce = 1'b1; i_cycle = 9'd256; i_scanline = 9'd0;
        i_render_en = 1'b1; i_obj_size = 1'b0; i_obj_base = 1'b1;
        i_oam_bus = 8'h00; i_vram_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        i_rst = 1'b0;
        i_cycle = 9'd0;
        @(posedge clk);
        #1;

        setup_a();
        run_line("a8x8", 1'b0, 0, 0, 0, 0, 8, 16, 1'b1);
        i_scanline = 9'd261;
        run_line("a_ce", 1'b1, 0, 0, 0, 0, 8, 16, 1'b1);
        i_scanline = 9'd0;

        setup_c();
        i_obj_size = 1'b1;
        run_line("c8x16", 1'b0, 0, 0, 0, 0, 8, 16, 1'b1);
        i_obj_size = 1'b0;

        setup_a();
        run_line("drop", 1'b0, 290, 0, 0, 0, 4, 8, 1'b0);
        run_line("rst", 1'b0, 0, 300, 0, 0, 5, 11, 1'b0);
        run_line("jump", 1'b0, 0, 0, 270, 280, 1, 3, 1'b0);
        i_scanline = 9'd240;
        run_line("line240", 1'b0, 0, 0, 0, 0, 0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
